// File: rtl/stream_pkt_arbiter_pkg.sv
// Shared types and width helpers for the packet arbiter slice.
package stream_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;

    function automatic int unsigned src_w(input int unsigned n);
        return (n < 3) ? 1 : $clog2(n);
    endfunction

    // Width of a packed {data, last, src} beat, for sizing the skid buffer payload.
    function automatic int unsigned beat_w(input int unsigned data_w, input int unsigned s_w);
        return data_w + 1 + s_w;
    endfunction

endpackage

// File: rtl/stream_pkt_arbiter_if.sv
// Bundled source-side and merged-side stream signals of the packet arbiter.
interface stream_pkt_arbiter_if
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned SRC_W        = src_w(N_SRC)
);
    logic [T_DATA_WIDTH-1:0] s_data_i [N_SRC];
    logic [N_SRC-1:0]        s_last_i;
    logic [N_SRC-1:0]        s_valid_i;
    logic [N_SRC-1:0]        s_ready_o;
    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic                    m_last_o;
    logic [SRC_W-1:0]        m_src_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    // master: the arbiter, which drives the merged stream
    modport master (
        input  s_data_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_src_o, m_valid_o
    );

    modport slave (
        output s_data_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_src_o, m_valid_o
    );
endinterface

// File: rtl/stream_skid_buffer.sv
// Two-entry FIFO skid buffer; input ready depends only on registered occupancy.
module stream_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             rd_q, rd_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push, pop, wr;

    always_comb begin
        in_ready_o  = (cnt_q != 2'd2);
        out_valid_o = (cnt_q != 2'd0);
        out_data_o  = out_valid_o ? mem_q[rd_q] : '0;
        push        = in_valid_i & in_ready_o;
        pop         = out_valid_o & out_ready_i;
        wr          = rd_q ^ cnt_q[0];
        mem_d       = mem_q;
        if (push) begin
            mem_d[wr] = in_data_i;
        end
        rd_d  = pop ? ~rd_q : rd_q;
        cnt_d = cnt_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-granular round-robin merge of N_SRC narrow streams with source tags.
module stream_pkt_arbiter
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned N_SRC        = 4,
    parameter int unsigned SRC_W        = src_w(N_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_pkt_arbiter_if.master bus
);
    localparam int unsigned BEAT_W = beat_w(T_DATA_WIDTH, SRC_W);

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic                    last;
        logic [SRC_W-1:0]        src;
    } beat_t;

    arb_state_t       state_q, state_d;
    logic [SRC_W-1:0] ptr_q, ptr_d;
    logic [SRC_W-1:0] grant_q, grant_d;
    logic [N_SRC-1:0] s_ready;
    logic             push, skid_ready;
    beat_t            in_beat, out_beat;
    logic [BEAT_W-1:0] out_raw;

    // First requester at or after ptr+1, wrapping modulo N_SRC.
    function automatic logic [SRC_W-1:0] rr_pick(input logic [N_SRC-1:0] req,
                                                 input logic [SRC_W-1:0] ptr);
        int unsigned idx;
        logic        found;
        rr_pick = '0;
        found   = 1'b0;
        for (int unsigned i = 1; i <= N_SRC; i++) begin
            idx = (32'(ptr) + i) % N_SRC;
            if (!found && req[idx]) begin
                rr_pick = SRC_W'(idx);
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        s_ready = '0;
        push    = 1'b0;
        in_beat = '{data: bus.s_data_i[grant_q], last: bus.s_last_i[grant_q], src: grant_q};
        case (state_q)
            IDLE: begin
                if (|bus.s_valid_i) begin
                    grant_d = rr_pick(bus.s_valid_i, ptr_q);
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                s_ready[grant_q] = skid_ready;
                push = bus.s_valid_i[grant_q] & skid_ready;
                if (push && bus.s_last_i[grant_q]) begin
                    ptr_d   = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= SRC_W'(N_SRC - 1);
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    stream_skid_buffer #(
        .WIDTH (BEAT_W)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_beat),
        .in_valid_i  (push),
        .in_ready_o  (skid_ready),
        .out_data_o  (out_raw),
        .out_valid_o (bus.m_valid_o),
        .out_ready_i (bus.m_ready_i)
    );

    assign out_beat      = beat_t'(out_raw);
    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = out_beat.data;
    assign bus.m_last_o  = out_beat.last;
    assign bus.m_src_o   = out_beat.src;

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Directed self-checking bench for stream_pkt_arbiter (8-bit beats, 4 sources).
module tb_stream_pkt_arbiter;
    logic clk;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    logic [8:0] sq [4][$];
    logic [3:0] hold;

    stream_pkt_arbiter_if #(.T_DATA_WIDTH(8), .N_SRC(4)) bus ();

    stream_pkt_arbiter #(
        .T_DATA_WIDTH (8),
        .N_SRC        (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.s_valid_i[i] = (sq[i].size() != 0) && !hold[i];
            bus.s_data_i[i]  = (sq[i].size() != 0) ? sq[i][0][7:0] : 8'h00;
            bus.s_last_i[i]  = (sq[i].size() != 0) ? sq[i][0][8] : 1'b0;
        end
    endtask

    // One clock: retire the beats handshaken at this edge, then re-drive.
    task automatic step();
        logic [3:0] acc;
        acc = bus.s_valid_i & bus.s_ready_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) void'(sq[i].pop_front());
        end
        drive();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic       t1_v [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0] t1_d [9] = '{8'h00, 8'hA0, 8'hA1, 8'hA2, 8'h00, 8'hC0, 8'hC1, 8'hC2, 8'h00};
    logic [1:0] t1_s [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 2'd0};
    logic       t1_l [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] t1_r [9] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};

    initial begin
        int j;
        rst_n         = 1'b0;
        hold          = '0;
        bus.m_ready_i = 1'b1;
        drive();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        chk("rst_s_ready", bus.s_ready_o, 4'h0);
        chk("rst_m_valid", bus.m_valid_o, 1'b0);
        chk("rst_m_last", bus.m_last_o, 1'b0);
        chk("rst_m_data", bus.m_data_o, 8'h00);
        chk("rst_m_src", bus.m_src_o, 2'd0);

        // Two 3-beat packets from sources 0 and 2 straight out of reset.
        sq[0].push_back({1'b0, 8'hA0});
        sq[0].push_back({1'b0, 8'hA1});
        sq[0].push_back({1'b1, 8'hA2});
        sq[2].push_back({1'b0, 8'hC0});
        sq[2].push_back({1'b0, 8'hC1});
        sq[2].push_back({1'b1, 8'hC2});
        drive();
        rst_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();
            chk($sformatf("t1_valid_e%0d", k + 1), bus.m_valid_o, t1_v[k]);
            chk($sformatf("t1_ready_e%0d", k + 1), bus.s_ready_o, t1_r[k]);
            if (t1_v[k]) begin
                chk($sformatf("t1_data_e%0d", k + 1), bus.m_data_o, t1_d[k]);
                chk($sformatf("t1_src_e%0d", k + 1), bus.m_src_o, t1_s[k]);
                chk($sformatf("t1_last_e%0d", k + 1), bus.m_last_o, t1_l[k]);
            end
        end

        // All four sources with two single-beat packets each.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sq[i].push_back({1'b1, 8'h10 + 8'(i)});
            sq[i].push_back({1'b1, 8'h20 + 8'(i)});
        end
        drive();
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k % 2 == 0) begin
                j = k / 2 - 1;
                chk($sformatf("t2_valid_e%0d", k), bus.m_valid_o, 1'b1);
                chk($sformatf("t2_src_e%0d", k), bus.m_src_o, j % 4);
                chk($sformatf("t2_data_e%0d", k), bus.m_data_o, ((j < 4) ? 8'h10 : 8'h20) + 8'(j % 4));
                chk($sformatf("t2_last_e%0d", k), bus.m_last_o, 1'b1);
            end else begin
                chk($sformatf("t2_valid_e%0d", k), bus.m_valid_o, 1'b0);
            end
        end

        // Source 1 stalls mid-packet while source 3 requests.
        do_reset();
        sq[1].push_back({1'b0, 8'hB0});
        sq[1].push_back({1'b0, 8'hB1});
        sq[1].push_back({1'b1, 8'hB2});
        drive();
        step();
        chk("t3_grant1", bus.s_ready_o, 4'h2);
        step();
        chk("t3_b0_data", bus.m_data_o, 8'hB0);
        chk("t3_b0_src", bus.m_src_o, 2'd1);
        hold[1] = 1'b1;
        sq[3].push_back({1'b1, 8'hD0});
        drive();
        for (int k = 3; k <= 5; k++) begin
            step();
            chk($sformatf("t3_hold_ready_e%0d", k), bus.s_ready_o, 4'h2);
            chk($sformatf("t3_hold_valid_e%0d", k), bus.m_valid_o, 1'b0);
        end
        hold[1] = 1'b0;
        drive();
        step();
        chk("t3_b1_data", bus.m_data_o, 8'hB1);
        chk("t3_b1_src", bus.m_src_o, 2'd1);
        step();
        chk("t3_b2_data", bus.m_data_o, 8'hB2);
        chk("t3_b2_last", bus.m_last_o, 1'b1);
        step();
        chk("t3_gap_valid", bus.m_valid_o, 1'b0);
        chk("t3_grant3", bus.s_ready_o, 4'h8);
        step();
        chk("t3_d0_data", bus.m_data_o, 8'hD0);
        chk("t3_d0_src", bus.m_src_o, 2'd3);
        chk("t3_d0_last", bus.m_last_o, 1'b1);
        step();

        // Back-pressure for five cycles during an 8-beat packet.
        do_reset();
        for (int i = 0; i < 8; i++) sq[0].push_back({(i == 7), 8'hE0 + 8'(i)});
        drive();
        step();
        step();
        chk("t4_e0_data", bus.m_data_o, 8'hE0);
        chk("t4_e0_ready", bus.s_ready_o, 4'h1);
        bus.m_ready_i = 1'b0;
        for (int k = 3; k <= 7; k++) begin
            step();
            chk($sformatf("t4_stall_valid_e%0d", k), bus.m_valid_o, 1'b1);
            chk($sformatf("t4_stall_data_e%0d", k), bus.m_data_o, 8'hE0);
            chk($sformatf("t4_stall_ready_e%0d", k), bus.s_ready_o, 4'h0);
        end
        chk("t4_beats_taken", sq[0].size(), 6);
        bus.m_ready_i = 1'b1;
        step();
        chk("t4_e1_data", bus.m_data_o, 8'hE1);
        chk("t4_release_ready", bus.s_ready_o, 4'h1);
        for (int n = 9; n <= 14; n++) begin
            step();
            chk($sformatf("t4_data_e%0d", n), bus.m_data_o, 8'hE0 + 8'(n - 7));
            chk($sformatf("t4_last_e%0d", n), bus.m_last_o, (n == 14));
        end
        step();
        chk("t4_drained", bus.m_valid_o, 1'b0);

        // Reset asserted with one beat buffered, mid-packet.
        do_reset();
        sq[2].push_back({1'b0, 8'hF0});
        sq[2].push_back({1'b0, 8'hF1});
        sq[2].push_back({1'b1, 8'hF2});
        drive();
        step();
        step();
        chk("t5_f0_valid", bus.m_valid_o, 1'b1);
        chk("t5_f0_data", bus.m_data_o, 8'hF0);
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", bus.m_valid_o, 1'b0);
        chk("t5_async_ready", bus.s_ready_o, 4'h0);
        sq[0].push_back({1'b1, 8'h60});
        drive();
        step();
        rst_n = 1'b1;
        step();
        chk("t5_grant0", bus.s_ready_o, 4'h1);
        chk("t5_no_output", bus.m_valid_o, 1'b0);
        step();
        chk("t5_g0_data", bus.m_data_o, 8'h60);
        chk("t5_g0_src", bus.m_src_o, 2'd0);
        repeat (6) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_pkt_arbiter.md
# stream_pkt_arbiter

Packet-granular round-robin arbiter that merges N_SRC narrow input streams into the single narrow stream feeding `stream_upsize`. A grant is held from a packet's first beat through its `last` beat, so packets are never interleaved and the upsizer always sees whole packets. A source tag travels with each beat. The output passes through a 2-entry skid buffer, so the registered output still runs at full throughput.

## Interface
- `T_DATA_WIDTH`, 1: width of one narrow beat; must match the downstream `stream_upsize`.
- `N_SRC`, 4: number of requesting streams, 2..16.
- `SRC_W`, `$clog2(N_SRC)`: width of the source tag. Derived; not overridden.
- `clk` in 1: the block's single clock; all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_data_i` in `[T_DATA_WIDTH-1:0]` x `[N_SRC]`: per-source beat data.
- `s_last_i` in `[N_SRC-1:0]`: per-source end-of-packet marker.
- `s_valid_i` in `[N_SRC-1:0]`: per-source valid.
- `s_ready_o` out `[N_SRC-1:0]`: per-source ready; at most one bit is set (one-hot or zero).
- `m_data_o` out `[T_DATA_WIDTH-1:0]`: merged beat data.
- `m_last_o` out 1: merged end-of-packet marker.
- `m_src_o` out `[SRC_W-1:0]`: index of the source that produced the beat.
- `m_valid_o` out 1: merged valid.
- `m_ready_i` in 1: downstream ready, driven by `stream_upsize`.

## Operation
- A beat transfers when valid and ready are both 1 at a clock edge. This holds on every port.
- FSM state `IDLE`:
  - All `s_ready_o` bits are 0.
  - If any `s_valid_i` bit is 1, the winner is the first requester at or after `ptr+1 (mod N_SRC)`, searching upward.
  - The winner is registered into `grant` and the FSM moves to `LOCKED`.
  - If no bit is set, the FSM stays in `IDLE`.
- FSM state `LOCKED`:
  - `s_ready_o[grant]` = skid buffer not full. All other bits are 0.
  - Each accepted beat is pushed into the skid buffer as `{data, last, grant}`.
  - An accepted beat with `last`=1 sets `ptr <= grant` and returns the FSM to `IDLE`.
- The grant is held while the granted source deasserts valid mid-packet. No switch happens without `last`.
- Requests from other sources during `LOCKED` are ignored until the FSM is back in `IDLE`.
- Skid buffer:
  - Capacity is 2 entries, in FIFO order.
  - Push and pop in the same cycle keep the occupancy unchanged.
  - `m_*` is driven from the head entry.
  - `m_valid_o` = occupancy != 0.
  - A head entry does not change while `m_valid_o`=1 and `m_ready_i`=0.
- Reset state: FSM in `IDLE`, `ptr` = N_SRC-1 (so source 0 wins first), `grant` = 0, skid buffer empty.
- Reset values of outputs: `s_ready_o`=0, `m_valid_o`=0, `m_last_o`=0, `m_data_o`=0, `m_src_o`=0.
- Reset mid-packet: the partial packet is discarded and the buffer is flushed. No output is produced until a new grant.

## Timing
- Arbitration takes one cycle: the `IDLE` cycle produces no `s_ready_o`. This is a 1-cycle bubble per packet.
- Beats within a packet are accepted every cycle while the buffer has room.
- Latency is 1 cycle: a beat accepted at edge k is on `m_*` with `m_valid_o`=1 after edge k.
- Back-pressure:
  - `m_ready_i`=0 fills the buffer after 2 accepts.
  - The cycle after the buffer becomes full, `s_ready_o`=0. Ready is computed from the registered occupancy.
  - One cycle after `m_ready_i` returns to 1, `s_ready_o` is 1 again.
- Single-beat packet (first beat has `last`=1): the FSM goes `IDLE` -> `LOCKED` -> `IDLE`, i.e. 2 cycles per packet per source.
- Minimum spacing between packets from different sources is 1 idle cycle.

## Structure
- Package `stream_pkg`:
  - `arb_state_t` enum {`IDLE`, `LOCKED`}.
  - Function `src_w(n)` = max(1, $clog2(n)).
  - Typedef helper for a beat struct `{data, last, src}`.
- Sub-module `stream_skid_buffer`: parameterised by payload width; 2 entries; valid/ready on both sides; async active-low reset.
- Round-robin search: a combinational function inside `stream_pkt_arbiter`. It is not a separate module.

## Test plan
- Sources 0 and 2 each present a 3-beat packet from reset, `m_ready_i`=1 -> output carries source 0 beats D0..D2 with `m_src_o`=0 and `last` on beat 3, then 1 idle cycle, then source 2 beats with `m_src_o`=2.
- All 4 sources continuously valid with 1-beat packets -> `m_src_o` sequence is 0,1,2,3,0,..., one beat every 2 cycles.
- Source 1 granted, drops `s_valid_i` for 3 cycles mid-packet while source 3 is valid -> no beats from source 3 until source 1 sends `last`.
- `m_ready_i`=0 for 5 cycles during an 8-beat packet -> exactly 2 beats buffered, `s_ready_o`=0, `m_data_o` stable; all 8 beats delivered in order after release, none duplicated.
- `rst_n` asserted mid-packet with 1 beat buffered -> `m_valid_o` and `s_ready_o` go to 0 immediately; after release, source 0 wins first.
